// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver; 2-flop synchroniser, centre sampling, stop check
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS = FREQ / BAUD;
  localparam int HALF = CLKS / 2;
  localparam logic [7:0] CLKS_M1 = 8'(CLKS - 1);
  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic       sync1_q, sync2_q;
  logic [2:0] state_q, state_d;
  logic [7:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = 8'd0;
        end
      end
      S_START: begin
        // Start bit re-checked at its centre; a high line here was a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = 8'd0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CLKS_M1) begin
          clk_cnt_d = 8'd0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next start.
        if (clk_cnt_q == CLKS_M1) begin
          clk_cnt_d = 8'd0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= 8'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
